// File: rtl/cpu_pkg.sv
// Shared definitions for the PureFPGA front-end sequencer: widths, register
// indices, the core NOP word, condition/op codes and the flag bundle.
package cpu_pkg;

  localparam int WIDTH       = 16;
  localparam int REGS_CODING = 8;

  localparam int REG_SP = 6;
  localparam int REG_IP = 7;

  // Word issued to the vector core whenever nothing is forwarded.
  localparam logic [14:0] NOP = 15'h42C0;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_CS = 4'h3;
  localparam logic [3:0] COND_CC = 4'h4;
  localparam logic [3:0] COND_MI = 4'h5;
  localparam logic [3:0] COND_PL = 4'h6;
  localparam logic [3:0] COND_VS = 4'h7;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_NOT = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  // Sub-opcodes of the ROMData[15:14]=00 group.
  localparam logic [1:0] SUB_MOVI  = 2'b01;
  localparam logic [4:0] OPC_LOAD  = 5'b00001;
  localparam logic [4:0] OPC_STORE = 5'b00011;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  // Condition evaluation; every unlisted code (including 1111) never executes.
  function automatic logic cond_met(input logic [3:0] cond, input flags_t f);
    logic ok;
    case (cond)
      COND_AL: ok = 1'b1;
      COND_EQ: ok = f.z;
      COND_NE: ok = ~f.z;
      COND_CS: ok = f.c;
      COND_CC: ok = ~f.c;
      COND_MI: ok = f.n;
      COND_PL: ok = ~f.n;
      COND_VS: ok = f.v;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ip_alu.sv
// Combinational op/flag unit for local ALU instructions. Produces the result,
// whether it should be written back, and the updated flag set.
module ip_alu
  import cpu_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] dst_i,
  input  logic [WIDTH-1:0] src_i,
  input  flags_t           flags_i,
  output logic [WIDTH-1:0] result_o,
  output logic             we_o,
  output flags_t           flags_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           upd_zn;

  assign sum  = {1'b0, dst_i} + {1'b0, src_i};
  assign diff = {1'b0, dst_i} - {1'b0, src_i};

  // Operation select; mov is a pure copy and leaves all flags alone.
  always_comb begin
    result_o = '0;
    we_o     = 1'b0;
    upd_zn   = 1'b0;
    flags_o  = flags_i;
    case (op_i)
      OP_MOV: begin result_o = src_i;          we_o = 1'b1; end
      OP_NOT: begin result_o = ~src_i;         we_o = 1'b1; upd_zn = 1'b1; end
      OP_AND: begin result_o = dst_i & src_i;  we_o = 1'b1; upd_zn = 1'b1; end
      OP_OR:  begin result_o = dst_i | src_i;  we_o = 1'b1; upd_zn = 1'b1; end
      OP_XOR: begin result_o = dst_i ^ src_i;  we_o = 1'b1; upd_zn = 1'b1; end
      OP_SHL: begin result_o = dst_i << 1;     we_o = 1'b1; upd_zn = 1'b1; end
      OP_SHR: begin result_o = dst_i >> 1;     we_o = 1'b1; upd_zn = 1'b1; end
      OP_ADD: begin
        result_o  = sum[WIDTH-1:0];
        we_o      = 1'b1;
        upd_zn    = 1'b1;
        flags_o.c = sum[WIDTH];
        flags_o.v = (dst_i[WIDTH-1] == src_i[WIDTH-1]) &&
                    (sum[WIDTH-1] != dst_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        result_o  = diff[WIDTH-1:0];
        we_o      = (op_i == OP_SUB);
        upd_zn    = 1'b1;
        // Carry means "no borrow" for subtraction.
        flags_o.c = ~diff[WIDTH];
        flags_o.v = (dst_i[WIDTH-1] != src_i[WIDTH-1]) &&
                    (diff[WIDTH-1] != dst_i[WIDTH-1]);
      end
      default: ;
    endcase
    if (upd_zn) begin
      flags_o.z = (result_o == '0);
      flags_o.n = result_o[WIDTH-1];
    end
  end

endmodule

// File: rtl/instruction_processor.sv
// Front-end sequencer: owns ip, sp, reg0..reg5 and the Z/C/N/V flags, drives
// the ROM address from ip and splits ROM words between the vector core and
// local execution. External register loads take priority over execution.
module instruction_processor
  import cpu_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REGS_CODING-1:0] regChoose,
  input  logic [WIDTH-1:0]       regData,
  input  logic [WIDTH-1:0]       ROMData,
  output logic [14:0]            instructionOut,
  output logic [WIDTH-1:0]       ROMAddress
);

  logic [WIDTH-1:0] regs_q [REGS_CODING];
  logic [WIDTH-1:0] regs_d [REGS_CODING];
  flags_t           flags_q, flags_d;

  logic             load_cycle;
  logic             is_core, is_alu, is_movi, is_mem;
  logic [3:0]       cond;
  logic [3:0]       op;
  logic [2:0]       dst_idx, src_idx, movi_idx;
  logic [7:0]       imm8;
  logic             alu_go;
  logic [WIDTH-1:0] alu_result;
  logic             alu_we;
  flags_t           alu_flags;

  assign load_cycle = |regChoose;

  assign is_core = ROMData[15];
  assign is_alu  = (ROMData[15:14] == 2'b01);
  assign is_movi = (ROMData[15:14] == 2'b00) && (ROMData[13:12] == SUB_MOVI);
  assign is_mem  = (ROMData[15:14] == 2'b00) &&
                   ((ROMData[13:9] == OPC_LOAD) || (ROMData[13:9] == OPC_STORE));

  assign cond     = ROMData[13:10];
  assign op       = ROMData[9:6];
  assign dst_idx  = ROMData[5:3];
  assign src_idx  = ROMData[2:0];
  assign movi_idx = {1'b0, ROMData[10:9]};
  assign imm8     = ROMData[8:1];

  assign alu_go = ~load_cycle && is_alu && cond_met(cond, flags_q);

  ip_alu u_alu (
    .op_i     (op),
    .dst_i    (regs_q[dst_idx]),
    .src_i    (regs_q[src_idx]),
    .flags_i  (flags_q),
    .result_o (alu_result),
    .we_o     (alu_we),
    .flags_o  (alu_flags)
  );

  // Register file, ip and flag state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS_CODING; i++)
        regs_q[i] <= (i == REG_SP) ? '1 : '0;
      flags_q <= '0;
    end else begin
      for (int i = 0; i < REGS_CODING; i++)
        regs_q[i] <= regs_d[i];
      flags_q <= flags_d;
    end
  end

  // Next state: loads win outright; otherwise ip advances unless an ALU write to ip jumps.
  always_comb begin
    for (int i = 0; i < REGS_CODING; i++)
      regs_d[i] = regs_q[i];
    flags_d = flags_q;
    if (load_cycle) begin
      for (int i = 0; i < REGS_CODING; i++)
        if (regChoose[i]) regs_d[i] = regData;
    end else begin
      regs_d[REG_IP] = regs_q[REG_IP] + 16'd1;
      if (alu_go) begin
        flags_d = alu_flags;
        if (alu_we) regs_d[dst_idx] = alu_result;
      end
      if (is_movi) begin
        if (ROMData[11]) regs_d[movi_idx][7:0]  = imm8;
        else             regs_d[movi_idx][15:8] = imm8;
      end
    end
  end

  // Issue decode: forward core and memory words, NOP for everything else and during reset.
  always_comb begin
    instructionOut = NOP;
    if (!reset && !load_cycle && (is_core || is_mem))
      instructionOut = ROMData[14:0];
  end

  assign ROMAddress = regs_q[REG_IP];

endmodule

// File: tb/tb_instruction_processor.sv
// Self-checking bench for instruction_processor: directed scenarios followed by
// random traffic, all checked against an arithmetic reference model.
module tb_instruction_processor;

  localparam logic [14:0] NOP_W = 15'h42C0;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  regChoose;
  logic [15:0] regData;
  logic [15:0] ROMData;
  logic [14:0] instructionOut;
  logic [15:0] ROMAddress;

  int n_vec = 0;
  int n_bad = 0;

  int unsigned m_r [8];
  bit mz, mc, mn, mv;

  instruction_processor dut (
    .clock          (clock),
    .reset          (reset),
    .regChoose      (regChoose),
    .regData        (regData),
    .ROMData        (ROMData),
    .instructionOut (instructionOut),
    .ROMAddress     (ROMAddress)
  );

  always #5 clock = ~clock;

  task automatic check15(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic logic [15:0] alu(input int cond, input int op, input int d, input int s);
    return {2'b01, 4'(cond), 4'(op), 3'(d), 3'(s)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_r[6] = 16'hFFFF;
    mz = 0; mc = 0; mn = 0; mv = 0;
  endtask

  // One clock of stimulus: check issue word before the edge, ip after it.
  task automatic step(input logic [7:0] rc, input logic [15:0] rd,
                      input logic [15:0] rom, input string tag);
    logic [14:0] exp_out;
    int unsigned nip, a, b, res, imm;
    int s, cond, op, d, sidx, idx;
    bit ok, wr, zn;
    regChoose = rc; regData = rd; ROMData = rom;
    #1;
    if (rc != 0) exp_out = NOP_W;
    else if (rom[15]) exp_out = rom[14:0];
    else if (rom[15:14] == 2'b00 && (rom[13:9] == 5'd1 || rom[13:9] == 5'd3)) exp_out = rom[14:0];
    else exp_out = NOP_W;
    check15({tag, ".out"}, instructionOut, exp_out);
    @(posedge clock);
    if (rc != 0) begin
      for (int i = 0; i < 8; i++) if (rc[i]) m_r[i] = rd;
    end else begin
      nip = (m_r[7] + 1) % 65536;
      if (rom[15:14] == 2'b01) begin
        cond = int'(rom[13:10]); op = int'(rom[9:6]); d = int'(rom[5:3]); sidx = int'(rom[2:0]);
        case (cond)
          0: ok = 1;   1: ok = mz;  2: ok = !mz; 3: ok = mc;
          4: ok = !mc; 5: ok = mn;  6: ok = !mn; 7: ok = mv;
          default: ok = 0;
        endcase
        if (ok) begin
          a = m_r[d]; b = m_r[sidx]; wr = 0; zn = 0; res = 0;
          case (op)
            0:  begin res = b; wr = 1; end
            1:  begin res = (~b) & 32'hFFFF; wr = 1; zn = 1; end
            2:  begin res = a & b; wr = 1; zn = 1; end
            3:  begin res = a | b; wr = 1; zn = 1; end
            4:  begin res = a ^ b; wr = 1; zn = 1; end
            5:  begin res = (a * 2) % 65536; wr = 1; zn = 1; end
            6:  begin res = a / 2; wr = 1; zn = 1; end
            10: begin
              res = a + b; mc = (res > 65535); res = res % 65536;
              s = sgn(a) + sgn(b); mv = (s > 32767 || s < -32768);
              wr = 1; zn = 1;
            end
            11, 12: begin
              mc = (a >= b); res = (a + 65536 - b) % 65536;
              s = sgn(a) - sgn(b); mv = (s > 32767 || s < -32768);
              wr = (op == 11); zn = 1;
            end
            default: ;
          endcase
          if (zn) begin mz = (res == 0); mn = (res >= 32768); end
          if (wr) begin
            if (d == 7) nip = res;
            else m_r[d] = res;
          end
        end
      end else if (rom[15:14] == 2'b00 && rom[13:12] == 2'b01) begin
        idx = int'(rom[10:9]); imm = int'(rom[8:1]);
        if (rom[11]) m_r[idx] = (m_r[idx] & 32'hFF00) | imm;
        else         m_r[idx] = (m_r[idx] & 32'h00FF) | (imm * 256);
      end
      m_r[7] = nip;
    end
    #1;
    check16({tag, ".addr"}, ROMAddress, 16'(m_r[7]));
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int k;
    w = 16'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      0, 1: w[15] = 1'b1;
      2, 3, 4, 5: begin
        w[15:14] = 2'b01;
        if ($urandom_range(0, 3) != 0) w[13:10] = 4'($urandom_range(0, 7));
      end
      6: w[15:12] = 4'b0001;
      7: begin
        w[15:14] = 2'b00;
        w[13:9]  = ($urandom_range(0, 1) == 1) ? 5'b00001 : 5'b00011;
      end
      default: w[15] = 1'b0;
    endcase
    return w;
  endfunction

  initial begin
    logic [7:0] rc;
    reset = 1'b1; regChoose = '0; regData = '0; ROMData = 16'hC281;
    model_reset();
    #2;
    check15("rst.out", instructionOut, NOP_W);
    check16("rst.addr", ROMAddress, 16'h0000);
    @(negedge clock);
    check15("rst.out_hold", instructionOut, NOP_W);
    reset = 1'b0;

    // External loads: ip, reg2, sp; ip must not advance.
    step(8'h80, 16'h0000, 16'hC281, "t2_ip");
    step(8'h04, 16'd10,   16'hC281, "t2_r2");
    step(8'h40, 16'hFFFF, 16'hC281, "t2_sp");
    step(8'h00, 16'h0000, alu(0, 0, 7, 6), "t2_rdsp");
    check16("t2_sp_lit", ROMAddress, 16'hFFFF);
    step(8'h80, 16'h0000, 16'hC281, "t2_iprst");

    // Core instruction forwarded, ip 0 -> 1.
    step(8'h00, 16'h0000, 16'b1100_0010_1000_0001, "t3_core");
    check16("t3_lit", ROMAddress, 16'h0001);

    // reg0 = 13 + reg2(10) = 23; flag checks through conditional jumps.
    step(8'h01, 16'd13, 16'h0000, "t4_ld");
    step(8'h00, 16'h0000, alu(0, 10, 0, 2), "t4_add");
    step(8'h00, 16'h0000, alu(0, 0, 7, 0), "t4_rd0");
    check16("t4_lit", ROMAddress, 16'd23);
    step(8'h00, 16'h0000, alu(3, 0, 7, 2), "t4_cs");
    step(8'h00, 16'h0000, alu(4, 0, 7, 2), "t4_cc");
    step(8'h00, 16'h0000, alu(1, 0, 7, 0), "t4_eq");

    // Move-immediate low byte keeps the high byte; memory ops forwarded.
    step(8'h02, 16'hAB12, 16'h0000, "t5_ld");
    step(8'h00, 16'h0000, 16'b0001_1011_1111_1100, "t5_movi");
    step(8'h00, 16'h0000, alu(0, 0, 7, 1), "t5_rd1");
    check16("t5_lit", ROMAddress, 16'hABFE);
    step(8'h00, 16'h0000, 16'b0000_0110_1001_0000, "t5_store");
    step(8'h00, 16'h0000, 16'b0000_0010_1001_1000, "t5_load");

    // cmp equal then EQ jump taken, NE jump not taken.
    step(8'h00, 16'h0000, alu(0, 12, 0, 0), "t6_cmp");
    step(8'h00, 16'h0000, alu(1, 0, 7, 2), "t6_eq");
    check16("t6_lit", ROMAddress, 16'd10);
    step(8'h00, 16'h0000, alu(2, 0, 7, 2), "t6_ne");
    check16("t6_ne_lit", ROMAddress, 16'd11);

    // Signed overflow on 0x8000 - 1, never-condition, ip wrap.
    step(8'h08, 16'h8000, 16'h0000, "ov_ld3");
    step(8'h10, 16'h0001, 16'h0000, "ov_ld4");
    step(8'h00, 16'h0000, alu(0, 11, 3, 4), "ov_sub");
    step(8'h00, 16'h0000, alu(7, 0, 7, 4), "ov_vs");
    step(8'h00, 16'h0000, alu(15, 0, 7, 6), "never");
    step(8'h80, 16'hFFFF, 16'h0000, "wrap_ld");
    step(8'h00, 16'h0000, 16'hC281, "wrap");
    check16("wrap_lit", ROMAddress, 16'h0000);

    // Random traffic with occasional external loads.
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      step(rc, 16'($urandom), rand_word(), "rnd");
    end
    for (int r = 0; r < 7; r++)
      step(8'h00, 16'h0000, alu(0, 0, 7, r), "rdbk");

    // Asynchronous reset mid-cycle.
    #3;
    ROMData = 16'hC281;
    reset = 1'b1;
    #1;
    model_reset();
    check15("arst.out", instructionOut, NOP_W);
    check16("arst.addr", ROMAddress, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    step(8'h00, 16'h0000, alu(0, 0, 7, 6), "arst_sp");
    for (int i = 0; i < 50; i++)
      step(8'h00, 16'($urandom), rand_word(), "rnd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
